// File: rtl/cfg_space_responder_pkg.sv
// Shared definitions for the config-space responder: Type-0 header dword
// offsets, FSM state encoding, BAR type nibble, and latency LFSR constants.
package cfg_space_responder_pkg;

    localparam int NUM_BARS    = 6;
    localparam int HDR_DWORDS  = 16;

    localparam logic [3:0] DW_ID         = 4'd0;
    localparam logic [3:0] DW_CMD_STATUS = 4'd1;
    localparam logic [3:0] DW_CLASS      = 4'd2;
    localparam logic [3:0] DW_BAR0       = 4'd4;
    localparam logic [3:0] DW_BAR1       = 4'd5;
    localparam logic [3:0] DW_BAR2       = 4'd6;
    localparam logic [3:0] DW_BAR3       = 4'd7;
    localparam logic [3:0] DW_BAR4       = 4'd8;
    localparam logic [3:0] DW_BAR5       = 4'd9;

    // Status half of dword1 is constant: capabilities-list bit only.
    localparam logic [15:0] STATUS_RO = 16'h0010;
    // Only command bits [10:0] are implemented.
    localparam logic [15:0] CMD_WMASK = 16'h07FF;

    // 32-bit, non-prefetchable memory BAR.
    localparam logic [3:0] BAR_TYPE_MEM32 = 4'b0000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } cfg_state_t;

    // Expand per-byte enables into a per-bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/cfg_space_responder_lat_lfsr.sv
// 16-bit Galois LFSR used to jitter the responder's completion latency.
// Only compiled when CFG_RESP_RANDOM_LATENCY_EN is defined; the default
// build carries no LFSR logic at all.
`ifdef CFG_RESP_RANDOM_LATENCY_EN
module cfg_lat_lfsr
    import cfg_space_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Load the seed on reset, otherwise shift right and fold taps in when a one falls out
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
        end
    end

endmodule
`endif

// File: rtl/cfg_space_responder.sv
// Responder for the PCIe core CFG management port. Answers dword reads and
// writes of a Type-0 header (dwords 0-15) with BAR size masks so BAR probing
// works. READ_LATENCY must be at least 1.
// Optional feature: define CFG_RESP_RANDOM_LATENCY_EN to add 0-7 extra
// cycles of latency per access, drawn from a free-running LFSR.
module cfg_space_responder
    import cfg_space_responder_pkg::*;
#(
    parameter int          READ_LATENCY = 3,
    parameter logic [15:0] VENDOR_ID    = 16'h10EE,
    parameter logic [15:0] DEVICE_ID    = 16'h0007,
    parameter logic [31:0] CLASS_REV    = 32'h05800000,
    parameter logic [31:0] BAR0_MASK    = 32'hFFFFF000,
    parameter logic [31:0] BAR1_MASK    = 32'h00000000,
    parameter logic [31:0] BAR2_MASK    = 32'h00000000,
    parameter logic [31:0] BAR3_MASK    = 32'h00000000,
    parameter logic [31:0] BAR4_MASK    = 32'h00000000,
    parameter logic [31:0] BAR5_MASK    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_cfg_dwaddr,
    input  logic        i_cfg_rd_en,
    input  logic        i_cfg_wr_en,
    input  logic [31:0] i_cfg_di,
    input  logic [3:0]  i_cfg_byte_en,
    output logic [31:0] o_cfg_do,
    output logic        o_cfg_rd_wr_done,
    output logic [15:0] o_cmd_reg
);

    localparam int CNT_W = $clog2(READ_LATENCY + 8);
    localparam logic [31:0] BAR_MASKS [NUM_BARS] = '{
        BAR0_MASK, BAR1_MASK, BAR2_MASK, BAR3_MASK, BAR4_MASK, BAR5_MASK
    };

    cfg_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [9:0]         lat_addr;
    logic [31:0]        lat_di;
    logic [3:0]         lat_be;
    logic               lat_wr;
    logic [15:0]        cmd;
    logic [15:0]        cmd_post;
    logic [31:0]        be_bits;
    logic [31:0]        bar_post [NUM_BARS];
    logic [31:0]        rd_data;
    logic               complete;
    logic [2:0]         extra_lat;

`ifdef CFG_RESP_RANDOM_LATENCY_EN
    logic [15:0] lfsr_state;

    cfg_lat_lfsr u_lat_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    assign extra_lat = lfsr_state[2:0];
`else
    assign extra_lat = 3'd0;
`endif

    assign complete  = (state == ST_COUNT) && (cnt == '0);
    assign be_bits   = lane_mask(lat_be);
    assign o_cmd_reg = cmd;

    // Command register value after the latched access, used for both commit and read-back
    always_comb begin
        cmd_post = cmd;
        if (lat_wr && (lat_addr == {6'd0, DW_CMD_STATUS})) begin
            cmd_post = (lat_di[15:0] & CMD_WMASK & be_bits[15:0])
                     | (cmd & ~(CMD_WMASK & be_bits[15:0]));
        end
    end

    // Each BAR keeps only its writable bits above the type nibble; unimplemented BARs stay zero
    for (genvar n = 0; n < NUM_BARS; n++) begin : g_bar
        localparam logic [31:0] WMASK = BAR_MASKS[n] & 32'hFFFFFFF0;

        logic [31:4] bar_q;
        logic [31:4] bar_next;
        logic        hit;

        assign hit      = lat_wr && (lat_addr == ({6'd0, DW_BAR0} + 10'(n)));
        assign bar_next = hit ? ((lat_di[31:4] & WMASK[31:4] & be_bits[31:4])
                              | (bar_q & ~(WMASK[31:4] & be_bits[31:4])))
                              : bar_q;
        assign bar_post[n] = {bar_next, BAR_TYPE_MEM32};

        // Commit this BAR's masked write when the access completes
        always_ff @(posedge clk) begin
            if (rst) begin
                bar_q <= '0;
            end else if (complete) begin
                bar_q <= bar_next;
            end
        end
    end

    // Read mux over post-write values so a combined read/write returns the new contents
    always_comb begin
        rd_data = '0;
        if (lat_addr < 10'(HDR_DWORDS)) begin
            case (lat_addr[3:0])
                DW_ID:         rd_data = {DEVICE_ID, VENDOR_ID};
                DW_CMD_STATUS: rd_data = {STATUS_RO, cmd_post};
                DW_CLASS:      rd_data = CLASS_REV;
                DW_BAR0:       rd_data = bar_post[0];
                DW_BAR1:       rd_data = bar_post[1];
                DW_BAR2:       rd_data = bar_post[2];
                DW_BAR3:       rd_data = bar_post[3];
                DW_BAR4:       rd_data = bar_post[4];
                DW_BAR5:       rd_data = bar_post[5];
                default:       rd_data = '0;
            endcase
        end
    end

    // Request handshake: accept, count down the latency, complete, then wait for release
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            lat_addr         <= '0;
            lat_di           <= '0;
            lat_be           <= '0;
            lat_wr           <= 1'b0;
            cmd              <= '0;
            o_cfg_do         <= '0;
            o_cfg_rd_wr_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cfg_rd_en || i_cfg_wr_en) begin
                        lat_addr <= i_cfg_dwaddr;
                        lat_di   <= i_cfg_di;
                        lat_be   <= i_cfg_byte_en;
                        lat_wr   <= i_cfg_wr_en;
                        cnt      <= CNT_W'(READ_LATENCY - 1) + CNT_W'(extra_lat);
                        state    <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (cnt == '0) begin
                        cmd              <= cmd_post;
                        o_cfg_do         <= rd_data;
                        o_cfg_rd_wr_done <= 1'b1;
                        state            <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!i_cfg_rd_en && !i_cfg_wr_en) begin
                        o_cfg_rd_wr_done <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_space_responder.sv
// Self-checking bench for cfg_space_responder (default build, fixed latency).
// A behavioural model of the header registers predicts done, read data and
// the command register every cycle; directed accesses pin the model with
// hand-computed values, then randomized accesses exercise it broadly.
module tb_cfg_space_responder;

    localparam int LAT = 3;
    localparam logic [31:0] BAR_MASKS [6] = '{
        32'hFFFFF000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  dwaddr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] di = '0;
    logic [3:0]  be = '0;
    logic [31:0] cfg_do;
    logic        done;
    logic [15:0] cmd_reg;

    int testsRun = 0;
    int testsFailed = 0;

    bit          checkOn = 1'b0;
    bit          expDone = 1'b0;
    logic [31:0] expDo = '0;
    logic [15:0] expCmd = '0;

    logic [15:0] mCmd = '0;
    logic [31:0] mBar [6];

    logic [31:0] gotDo;
    bit          doneEarly;
    bit          doneOnTime;

    cfg_space_responder #(.READ_LATENCY(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cfg_dwaddr     (dwaddr),
        .i_cfg_rd_en      (rd_en),
        .i_cfg_wr_en      (wr_en),
        .i_cfg_di         (di),
        .i_cfg_byte_en    (be),
        .o_cfg_do         (cfg_do),
        .o_cfg_rd_wr_done (done),
        .o_cmd_reg        (cmd_reg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of dword a must return, straight from the header layout.
    function automatic logic [31:0] mdlRead(input logic [9:0] a);
        if (a >= 10'd16) return 32'h0;
        case (a)
            10'd0:   return 32'h000710EE;
            10'd1:   return {16'h0010, mCmd};
            10'd2:   return 32'h05800000;
            10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9:
                     return mBar[a - 10'd4];
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdlWrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] lanes;
        logic [31:0] m;
        lanes = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        if (a == 10'd1) begin
            m = 32'h000007FF & lanes;
            mCmd = 16'((d & m) | ({16'h0, mCmd} & ~m));
        end else if (a >= 10'd4 && a <= 10'd9) begin
            m = BAR_MASKS[a - 10'd4] & lanes;
            mBar[a - 10'd4] = (d & m) | (mBar[a - 10'd4] & ~m);
        end
    endtask

    task automatic mdlReset();
        mCmd = '0;
        for (int i = 0; i < 6; i++) mBar[i] = '0;
        expCmd = '0;
        expDo = '0;
        expDone = 1'b0;
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("done", {31'b0, done}, {31'b0, expDone});
            checkOutput("cfg_do", cfg_do, expDo);
            checkOutput("cmd_reg", {16'b0, cmd_reg}, {16'b0, expCmd});
        end
    end

    // One complete access: request, fixed latency, done held for `hold` extra cycles, release.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [9:0] addr,
                                 input logic [31:0] data, input logic [3:0] bytes, input int hold);
        @(negedge clk);
        rd_en = rd; wr_en = wr; dwaddr = addr; di = data; be = bytes;
        @(posedge clk);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT) doneEarly = done;
            dwaddr = 10'($urandom);
            di = $urandom;
            be = 4'($urandom);
            @(posedge clk);
        end
        if (wr) mdlWrite(addr, data, bytes);
        expDo = mdlRead(addr);
        expCmd = mCmd;
        expDone = 1'b1;
        @(negedge clk);
        gotDo = cfg_do;
        doneOnTime = done;
        for (int h = 0; h < hold; h++) @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        expDone = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit rd, wr;
        logic [9:0] a;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        mdlReset();
        checkOn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_do", cfg_do, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        checkOutput("reset_cmd", {16'b0, cmd_reg}, 32'h0);

        applyStimulus(1, 0, 10'd0, 32'h0, 4'h0, 1);
        checkOutput("dw0_do", gotDo, 32'h000710EE);
        checkOutput("dw0_done_before_lat", {31'b0, doneEarly}, 32'h0);
        checkOutput("dw0_done_at_lat", {31'b0, doneOnTime}, 32'h1);

        applyStimulus(0, 1, 10'd4, 32'hFFFFFFFF, 4'hF, 0);
        applyStimulus(1, 0, 10'd4, 32'h0, 4'h0, 0);
        checkOutput("bar0_probe", gotDo, 32'hFFFFF000);
        applyStimulus(0, 1, 10'd5, 32'hFFFFFFFF, 4'hF, 0);
        applyStimulus(1, 0, 10'd5, 32'h0, 4'h0, 2);
        checkOutput("bar1_probe", gotDo, 32'h00000000);

        applyStimulus(0, 1, 10'd4, 32'h0, 4'hF, 0);
        applyStimulus(0, 1, 10'd4, 32'hD0000000, 4'b1000, 0);
        applyStimulus(1, 0, 10'd4, 32'h0, 4'h0, 0);
        checkOutput("bar0_byte3", gotDo, 32'hD0000000);

        for (int i = 4; i <= 9; i++) begin
            applyStimulus(1, 0, 10'(i), 32'h0, 4'h0, 0);
            checkOutput("bar_seq_done", {31'b0, doneOnTime}, 32'h1);
        end

        applyStimulus(1, 0, 10'h3FF, 32'h0, 4'h0, 1);
        checkOutput("addr_3ff_do", gotDo, 32'h0);

        applyStimulus(1, 1, 10'd1, 32'h00000406, 4'hF, 0);
        checkOutput("rdwr_dw1_do", gotDo, 32'h00100406);
        checkOutput("rdwr_dw1_cmd", {16'b0, cmd_reg}, 32'h00000406);

        @(negedge clk);
        wr_en = 1'b1; dwaddr = 10'd1; di = 32'h00000007; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        mdlReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            checkOutput("rst_in_count_done", {31'b0, done}, 32'h0);
        end
        checkOutput("rst_in_count_cmd", {16'b0, cmd_reg}, 32'h0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            a = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            applyStimulus(rd, wr, a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
